divider_sequencer: RTL and testbench
====================================

// Module: divider_sequencer
// PURPOSE
//  Run-time controller for the clock-division path. It produces a one-cycle tick enable and a
//  square-wave phase output from a programmable divisor, so no gated or derived clock is needed.
//  It accepts divisor and burst configuration through a valid/ready handshake.
//  It sequences start, stop and finite bursts, and applies reconfiguration only on period boundaries.
// PARAMETERS
//  CNT_W        11     width of divisor and period counter
//  DEFAULT_DIV  1040   divisor loaded at reset (cycles per tick)
//  BURST_W      16     width of burst length / tick counter
// PORTS
//  clock        in   1        system clock, all logic on posedge
//  reset_n      in   1        asynchronous active-low reset
//  cfg_valid    in   1        config offer
//  cfg_ready    out  1        config accept (transfer when valid&ready on posedge)
//  cfg_divisor  in   CNT_W    cycles per tick; values <2 saturate to 2
//  cfg_burst    in   BURST_W  ticks per run; 0 = free-running
//  start        in   1        level-sampled run request
//  stop         in   1        level-sampled stop request
//  tick         out  1        one-cycle enable at end of each period
//  phase        out  1        toggles on every tick (divide-by-2*div square wave)
//  busy         out  1        high in RUN/STOPPING
//  done         out  1        one-cycle pulse when returning to IDLE
//  tick_count   out  BURST_W  ticks emitted in current run
// BEHAVIOUR
//  Reset: state=IDLE, div_active=DEFAULT_DIV, burst=0, no pending cfg, count=0; outputs:
//   tick=0, phase=0, busy=0, done=0, cfg_ready=1, tick_count=0. All outputs registered.
//  FSM IDLE -> RUN on start&!stop; count cleared, tick_count cleared.
//   RUN -> STOPPING on stop (start ignored in RUN).
//   RUN -> IDLE when burst!=0 and the tick making tick_count==burst fires; done the same cycle+1.
//   STOPPING -> IDLE at the next wrap; the final tick IS emitted; done pulses.
//   In IDLE, stop has priority over start (both high = stay IDLE).
//  Counter: in RUN/STOPPING count 0..div_active-1. At count==div_active-1: count<=0,
//   tick<=1 next cycle, phase<=~phase, tick_count<=tick_count+1 (wraps modulo 2^BURST_W).
//  Latency: start sampled at edge k -> first tick high in cycle k+div_active; period = div_active.
//  Config, IDLE: cfg_ready=1; transfer writes div_active/burst directly.
//  Config, RUN/STOPPING: a one-entry pending slot; cfg_ready=!pending. Transfer fills slot;
//   slot copied to div_active/burst on the next wrap (same edge count resets), slot freed.
//   Transfer on the wrap edge itself lands in the slot and applies at the following wrap.
//  Burst change applied mid-run compares against tick_count as is; if tick_count>=new burst
//   (burst!=0), the run ends at that wrap.
//  Return to IDLE with a pending slot: slot applied on entry to IDLE.
//  phase holds its value in IDLE (not cleared by stop); only reset clears it.
//  Reset asserted mid-run: immediate return to reset values; no done pulse.
// STRUCTURE
//  Package divseq_pkg: state enum {IDLE,RUN,STOPPING} (2-bit), DIV_MIN=2, width localparams.
//  Sub-module period_counter (count, wrap flag, load of div_active) instantiated once;
//  FSM, config slot and tick/phase/done registers in top.
// TESTING
//  1 reset, start with DEFAULT_DIV -> first tick 1040 cycles after start, then every 1040; phase toggles.
//  2 cfg div=4 burst=3 in IDLE, start -> ticks at +4,+8,+12; done 1 cycle after 3rd; busy falls.
//  3 RUN div=10, cfg div=3 at count 5 -> cfg_ready drops; next tick at period 10, then every 3.
//  4 stop at count 2 of div=8 -> STOPPING, tick at count 7 wrap, done, IDLE; tick_count=N+1.
//  5 cfg div=0 and div=1 -> both behave as 2 (tick every 2 cycles, phase at clock/4).
//  6 reset_n low mid-run, and start&stop together in IDLE -> all reset values; stays IDLE, no tick.

Source files
------------

// File: rtl/divseq_pkg.sv
// Shared definitions for the divider sequencer.
// Holds the controller state encoding, the smallest usable divisor and
// the default widths that the top level and its period counter share.
package divseq_pkg;

    localparam int CNT_W_DEF       = 11;
    localparam int BURST_W_DEF     = 16;
    localparam int DEFAULT_DIV_DEF = 1040;

    // A period shorter than two cycles cannot produce a distinct tick/phase.
    localparam int DIV_MIN = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

endpackage

// File: rtl/divider_sequencer_period_counter.sv
// Period counter for the divider sequencer.
// Holds the active divisor and counts 0..div_active-1 while enabled.
// Ports:
//   clock     in   system clock
//   reset_n   in   asynchronous active-low reset
//   clear     in   force count to 0 (start of a run)
//   enable    in   count while high
//   load      in   replace the active divisor with load_div
//   load_div  in   divisor value to load (already saturated by the caller)
//   wrap      out  high in the last cycle of a period while enabled
module period_counter
    import divseq_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             wrap
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] div_active_reg;

    assign wrap = enable && (count_reg == (div_active_reg - CNT_W'(1)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg      <= '0;
            div_active_reg <= CNT_W'(DEFAULT_DIV);
        end else begin
            // A new divisor takes effect for the period that starts on this edge.
            if (load) begin
                div_active_reg <= load_div;
            end
            if (clear || wrap) begin
                count_reg <= '0;
            end else if (enable) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/divider_sequencer.sv
// Run-time controller for the clock-division path.
// Produces a one-cycle tick enable at the end of every period and a
// square-wave phase that toggles on each tick, sequences start/stop and
// finite bursts, and takes divisor/burst configuration over valid/ready.
// Configuration received while running waits in a one-entry slot and is
// applied only on a period boundary.
// Ports:
//   clock        in   system clock
//   reset_n      in   asynchronous active-low reset
//   cfg_valid    in   configuration offer
//   cfg_ready    out  configuration accept
//   cfg_divisor  in   cycles per tick (values below 2 act as 2)
//   cfg_burst    in   ticks per run, 0 = free-running
//   start        in   run request (level)
//   stop         in   stop request (level)
//   tick         out  one-cycle enable at the end of each period
//   phase        out  toggles on every tick
//   busy         out  high while running or stopping
//   done         out  one-cycle pulse after a run ends
//   tick_count   out  ticks emitted in the current run
module divider_sequencer
    import divseq_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
    parameter int BURST_W     = BURST_W_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_divisor,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               tick,
    output logic               phase,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] tick_count
);

    state_t             state_reg, state_next;
    logic [BURST_W-1:0] burst_reg, burst_next;
    logic               pend_reg, pend_next;
    logic [CNT_W-1:0]   slot_div_reg, slot_div_next;
    logic [BURST_W-1:0] slot_burst_reg, slot_burst_next;
    logic               tick_reg, tick_next;
    logic               phase_reg, phase_next;
    logic               busy_reg, busy_next;
    logic               finish_reg, finish_next;
    logic               done_reg;
    logic               cfg_ready_reg, cfg_ready_next;
    logic [BURST_W-1:0] tick_count_reg, tick_count_next;

    logic               transfer;
    logic [CNT_W-1:0]   cfg_div_sat;
    logic [BURST_W-1:0] tick_count_inc;
    logic [BURST_W-1:0] burst_eff;
    logic               ending;
    logic               wrap;
    logic               cnt_clear;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_div;

    assign transfer       = cfg_valid && cfg_ready_reg;
    assign cfg_div_sat    = (cfg_divisor < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : cfg_divisor;
    assign tick_count_inc = tick_count_reg + BURST_W'(1);

    period_counter #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_period_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (cnt_clear),
        .enable   (state_reg != IDLE),
        .load     (cnt_load),
        .load_div (cnt_load_div),
        .wrap     (wrap)
    );

    always_comb begin
        state_next      = state_reg;
        burst_next      = burst_reg;
        pend_next       = pend_reg;
        slot_div_next   = slot_div_reg;
        slot_burst_next = slot_burst_reg;
        tick_next       = 1'b0;
        phase_next      = phase_reg;
        finish_next     = 1'b0;
        tick_count_next = tick_count_reg;
        burst_eff       = burst_reg;
        ending          = 1'b0;
        cnt_clear       = 1'b0;
        cnt_load        = 1'b0;
        cnt_load_div    = slot_div_reg;

        case (state_reg)
            IDLE: begin
                if (transfer) begin
                    cnt_load     = 1'b1;
                    cnt_load_div = cfg_div_sat;
                    burst_next   = cfg_burst;
                end
                // stop wins when both requests are present
                if (start && !stop) begin
                    state_next      = RUN;
                    cnt_clear       = 1'b1;
                    tick_count_next = '0;
                end
            end

            RUN, STOPPING: begin
                if (wrap) begin
                    tick_next       = 1'b1;
                    phase_next      = ~phase_reg;
                    tick_count_next = tick_count_inc;
                    // A pending slot becomes active on this boundary, and its
                    // burst length already governs whether the run ends here.
                    if (pend_reg) begin
                        cnt_load     = 1'b1;
                        cnt_load_div = slot_div_reg;
                        burst_next   = slot_burst_reg;
                        burst_eff    = slot_burst_reg;
                        pend_next    = 1'b0;
                    end
                    ending = (state_reg == STOPPING) ||
                             ((burst_eff != '0) && (tick_count_inc >= burst_eff));
                    if (ending) begin
                        state_next  = IDLE;
                        finish_next = 1'b1;
                    end else if ((state_reg == RUN) && stop) begin
                        state_next = STOPPING;
                    end
                end else if ((state_reg == RUN) && stop) begin
                    state_next = STOPPING;
                end

                // Only possible with an empty slot, so never collides with the
                // slot load above. On the final edge of a run the slot would be
                // applied on entry to IDLE anyway, so it is written directly.
                if (transfer) begin
                    if (ending) begin
                        cnt_load     = 1'b1;
                        cnt_load_div = cfg_div_sat;
                        burst_next   = cfg_burst;
                    end else begin
                        pend_next       = 1'b1;
                        slot_div_next   = cfg_div_sat;
                        slot_burst_next = cfg_burst;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cfg_ready_next = (state_next == IDLE) ? 1'b1 : !pend_next;
    assign busy_next      = (state_next != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            burst_reg      <= '0;
            pend_reg       <= 1'b0;
            slot_div_reg   <= CNT_W'(DEFAULT_DIV);
            slot_burst_reg <= '0;
            tick_reg       <= 1'b0;
            phase_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            finish_reg     <= 1'b0;
            done_reg       <= 1'b0;
            cfg_ready_reg  <= 1'b1;
            tick_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            burst_reg      <= burst_next;
            pend_reg       <= pend_next;
            slot_div_reg   <= slot_div_next;
            slot_burst_reg <= slot_burst_next;
            tick_reg       <= tick_next;
            phase_reg      <= phase_next;
            busy_reg       <= busy_next;
            finish_reg     <= finish_next;
            // done trails the final tick by one cycle
            done_reg       <= finish_reg;
            cfg_ready_reg  <= cfg_ready_next;
            tick_count_reg <= tick_count_next;
        end
    end

    assign tick       = tick_reg;
    assign phase      = phase_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign cfg_ready  = cfg_ready_reg;
    assign tick_count = tick_count_reg;

endmodule

// File: tb/tb_divider_sequencer.sv
module tb_divider_sequencer;

    localparam int CNT_W   = 11;
    localparam int BURST_W = 16;
    localparam int DEF_DIV = 1040;

    logic               clock;
    logic               reset_n;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_divisor;
    logic [BURST_W-1:0] cfg_burst;
    logic               start;
    logic               stop;
    logic               tick;
    logic               phase;
    logic               busy;
    logic               done;
    logic [BURST_W-1:0] tick_count;

    divider_sequencer #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV),
        .BURST_W     (BURST_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_divisor (cfg_divisor),
        .cfg_burst   (cfg_burst),
        .start       (start),
        .stop        (stop),
        .tick        (tick),
        .phase       (phase),
        .busy        (busy),
        .done        (done),
        .tick_count  (tick_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // cyc == n at the negedge following the n-th rising edge
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit ph;
        int tc;
    } tick_exp_t;

    tick_exp_t tq[$];
    int        dq[$];
    int        checks = 0;
    int        errors = 0;
    bit        exp_phase = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push_one(input int c, input int tc);
        exp_phase = ~exp_phase;
        tq.push_back('{c, exp_phase, tc});
    endtask

    task automatic push_ticks(input int k, input int div, input int n, input int tc0);
        for (int i = 1; i <= n; i++) push_one(k + div * i, tc0 + i);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    task automatic do_cfg(input int div, input int burst);
        cfg_divisor = CNT_W'(div);
        cfg_burst   = BURST_W'(burst);
        cfg_valid   = 1'b1;
        @(negedge clock);
        cfg_valid   = 1'b0;
        $display("cfg transfer: div=%0d burst=%0d at cycle %0d", div, burst, cyc);
    endtask

    task automatic do_start(output int k);
        k     = cyc + 1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        $display("start sampled at edge %0d", k);
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        $display("stop sampled at edge %0d", cyc);
    endtask

    // Monitor: compares every tick/done the DUT presents against the queues.
    always @(negedge clock) begin
        tick_exp_t e;
        int        dc;
        if (tick === 1'b1) begin
            if (tq.size() == 0) begin
                chk("unexpected_tick", 1, 0);
            end else begin
                e = tq.pop_front();
                $display("tick: cycle=%0d phase=%0d tick_count=%0d", cyc, phase, tick_count);
                chk("tick_cycle", cyc, e.cyc);
                chk("tick_phase", phase, 32'(e.ph));
                chk("tick_count_at_tick", 32'(tick_count), e.tc);
            end
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                dc = dq.pop_front();
                $display("done: cycle=%0d", cyc);
                chk("done_cycle", cyc, dc);
            end
        end
    end

    initial begin
        int k;
        reset_n     = 1'b0;
        cfg_valid   = 1'b0;
        cfg_divisor = '0;
        cfg_burst   = '0;
        start       = 1'b0;
        stop        = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_tick", tick, 0);
        chk("rst_phase", phase, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_tick_count", 32'(tick_count), 0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_cfg_ready", cfg_ready, 1);
        chk("idle_busy", busy, 0);

        // 1: default divisor, free-running, then stop -> final tick emitted
        do_start(k);
        push_ticks(k, DEF_DIV, 3, 0);
        dq.push_back(k + 3 * DEF_DIV + 1);
        wait_cyc(k + DEF_DIV);
        chk("t1_busy_run", busy, 1);
        wait_cyc(k + 2 * DEF_DIV + 5);
        pulse_stop();
        wait_cyc(k + 3 * DEF_DIV + 3);
        chk("t1_busy_idle", busy, 0);
        chk("t1_tick_count", 32'(tick_count), 3);

        // 2: finite burst of 3 ticks at divisor 4
        do_cfg(4, 3);
        do_start(k);
        push_ticks(k, 4, 3, 0);
        dq.push_back(k + 13);
        wait_cyc(k + 11);
        chk("t2_busy_before_end", busy, 1);
        wait_cyc(k + 12);
        chk("t2_busy_falls", busy, 0);
        wait_cyc(k + 15);
        chk("t2_tick_count", 32'(tick_count), 3);

        // 3: reconfigure mid-period, applied on the next boundary
        do_cfg(10, 0);
        do_start(k);
        push_one(k + 10, 1);
        push_one(k + 13, 2);
        push_one(k + 16, 3);
        push_one(k + 19, 4);
        dq.push_back(k + 20);
        wait_cyc(k + 4);
        cfg_divisor = CNT_W'(3);
        cfg_burst   = '0;
        cfg_valid   = 1'b1;
        @(negedge clock);
        cfg_valid   = 1'b0;
        chk("t3_cfg_ready_pending", cfg_ready, 0);
        wait_cyc(k + 10);
        chk("t3_cfg_ready_freed", cfg_ready, 1);
        wait_cyc(k + 16);
        pulse_stop();
        wait_cyc(k + 22);
        chk("t3_busy_idle", busy, 0);

        // 4: stop early in a period of 8; the period still completes
        do_cfg(8, 0);
        do_start(k);
        push_ticks(k, 8, 1, 0);
        dq.push_back(k + 9);
        wait_cyc(k + 1);
        pulse_stop();
        chk("t4_busy_stopping", busy, 1);
        wait_cyc(k + 10);
        chk("t4_busy_idle", busy, 0);
        chk("t4_tick_count", 32'(tick_count), 1);

        // 5: divisors 0 and 1 saturate to 2
        do_cfg(0, 2);
        do_start(k);
        push_ticks(k, 2, 2, 0);
        dq.push_back(k + 5);
        wait_cyc(k + 7);
        do_cfg(1, 2);
        do_start(k);
        push_ticks(k, 2, 2, 0);
        dq.push_back(k + 5);
        wait_cyc(k + 7);
        chk("t5_tick_count", 32'(tick_count), 2);

        // 6: reset mid-run, then start&stop together in IDLE
        do_cfg(4, 0);
        do_start(k);
        push_ticks(k, 4, 1, 0);
        wait_cyc(k + 6);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_tick", tick, 0);
        chk("t6_rst_phase", phase, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_cfg_ready", cfg_ready, 1);
        chk("t6_rst_tick_count", 32'(tick_count), 0);
        exp_phase = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        start   = 1'b1;
        stop    = 1'b1;
        repeat (20) @(negedge clock);
        chk("t6_both_busy", busy, 0);
        chk("t6_both_tick_count", 32'(tick_count), 0);
        chk("t6_both_phase", phase, 0);
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) @(negedge clock);

        chk("tick_queue_empty", tq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
